// File: rtl/hd_unload_scheduler_if.sv
// hd_unload_scheduler_if: decoder, LLR-memory and output-FIFO signals of the unload scheduler
interface hd_unload_scheduler_if #(
    parameter int ADDRESSWIDTH = 5
);
    logic                    frame_done;
    logic                    fifo_ready;
    logic                    rd_en;
    logic [ADDRESSWIDTH-1:0] rd_addr;
    logic                    wr_en;
    logic [ADDRESSWIDTH-1:0] wr_addr;
    logic                    rd_start;
    logic                    busy;
    logic                    decoder_hold;
    logic                    overflow;

    modport master (
        output frame_done, fifo_ready,
        input  rd_en, rd_addr, wr_en, wr_addr, rd_start, busy, decoder_hold, overflow
    );
    modport slave (
        input  frame_done, fifo_ready,
        output rd_en, rd_addr, wr_en, wr_addr, rd_start, busy, decoder_hold, overflow
    );
endinterface

// File: rtl/hd_unload_scheduler.sv
// hd_unload_scheduler: unloads a decoded frame from LLR memory into the output FIFO, then
// hands a stretched start pulse to the FIFO read side.
module hd_unload_scheduler #(
    parameter int ADDRESSWIDTH    = 5,
    parameter int UNLOADCOUNT     = 17,
    parameter int RDLAT           = 2,
    parameter int SYNC_WAITCYCLES = 20
) (
    input logic                  clk,
    input logic                  rst,
    hd_unload_scheduler_if.slave bus
);
    localparam int CW = ADDRESSWIDTH > 8 ? ADDRESSWIDTH : 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SYNC} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    fd_q, fr_q;
    logic                    pending_q, pending_d;
    logic                    overflow_q, overflow_d;
    logic                    consume, last;
    logic                    rd_en;
    logic [ADDRESSWIDTH-1:0] rd_addr;
    logic [ADDRESSWIDTH:0]   pipe_q [RDLAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Inputs are registered once; the write pipeline mirrors the read request RDLAT cycles later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fd_q       <= 1'b0;
            fr_q       <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < RDLAT; i++) pipe_q[i] <= '0;
        end else begin
            fd_q       <= bus.frame_done;
            fr_q       <= bus.fifo_ready;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pipe_q[0]  <= {rd_en, rd_addr};
            for (int i = 1; i < RDLAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        consume    = state_q == IDLE && (fd_q || pending_q) && fr_q;
        last       = state_q == ISSUE ? cnt_q == CW'(UNLOADCOUNT - 1) :
                     state_q == DRAIN ? cnt_q == CW'(RDLAT - 1) :
                     state_q == SYNC  ? cnt_q == CW'(SYNC_WAITCYCLES - 1) : 1'b0;
        state_d    = !last ? (consume ? ISSUE : state_q) :
                     state_q == ISSUE ? DRAIN :
                     state_q == DRAIN ? SYNC : IDLE;
        cnt_d      = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        // A frame arriving on the consuming edge takes the freed pending slot.
        pending_d  = consume ? pending_q && fd_q : pending_q || fd_q;
        overflow_d = overflow_q || (fd_q && pending_q && !consume);
    end

    always_comb begin
        rd_en            = state_q == ISSUE;
        rd_addr          = rd_en ? cnt_q[ADDRESSWIDTH-1:0] : '0;
        bus.rd_en        = rd_en;
        bus.rd_addr      = rd_addr;
        bus.wr_en        = pipe_q[RDLAT-1][ADDRESSWIDTH];
        bus.wr_addr      = pipe_q[RDLAT-1][ADDRESSWIDTH-1:0];
        bus.rd_start     = state_q == SYNC;
        bus.busy         = state_q != IDLE;
        bus.decoder_hold = pending_q;
        bus.overflow     = overflow_q;
    end
endmodule

// File: tb/tb_hd_unload_scheduler.sv
// tb_hd_unload_scheduler: two configurations driven by one directed sequence, checked every
// cycle against a frame-schedule model plus literal expectations.
module tb_hd_unload_scheduler;
    localparam int U = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fd  = 1'b0;
    logic fr  = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    bit fd_h [0:1023];
    bit fr_h [0:1023];
    bit rst_h [0:1023];

    int lat [2] = '{2, 4};
    int wt  [2] = '{20, 3};
    int s_m [2] = '{-100000, -100000};
    bit pend [2] = '{0, 0};
    bit ovf  [2] = '{0, 0};

    hd_unload_scheduler_if #(.ADDRESSWIDTH(5)) b1 ();
    hd_unload_scheduler_if #(.ADDRESSWIDTH(5)) b2 ();

    assign b1.frame_done = fd;
    assign b1.fifo_ready = fr;
    assign b2.frame_done = fd;
    assign b2.fifo_ready = fr;

    hd_unload_scheduler dut1 (.clk(clk), .rst(rst), .bus(b1));
    hd_unload_scheduler #(.ADDRESSWIDTH(5), .UNLOADCOUNT(17), .RDLAT(4), .SYNC_WAITCYCLES(3))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A frame starts on the first cycle after an idle cycle at which a registered request
    // (new or pending) meets a registered fifo_ready; its outputs then follow a fixed schedule.
    task automatic mstep(input int d, input int c);
        bit efd, efr, cons;
        if (c < 3 || !rst_h[c-1]) begin
            s_m[d]  = -100000;
            pend[d] = 1'b0;
            ovf[d]  = 1'b0;
        end else begin
            efd  = fd_h[c-2] && rst_h[c-2];
            efr  = fr_h[c-2] && rst_h[c-2];
            cons = c >= s_m[d] + U + lat[d] + wt[d] + 1 && (efd || pend[d]) && efr;
            if (cons) begin
                pend[d] = pend[d] && efd;
                s_m[d]  = c;
            end else begin
                if (efd && pend[d]) ovf[d] = 1'b1;
                pend[d] = pend[d] || efd;
            end
        end
    endtask

    task automatic cmp(input int d, input int c);
        int k, t, ra, wa;
        bit re, we, rs, bz;
        k  = c - s_m[d];
        t  = U + lat[d] + wt[d];
        re = k >= 0 && k < U;
        ra = re ? k : 0;
        we = k >= lat[d] && k < lat[d] + U;
        wa = we ? k - lat[d] : 0;
        rs = k >= U + lat[d] && k < t;
        bz = k >= 0 && k < t;
        chk($sformatf("d%0d rd_en @%0d", d, c), d ? b2.rd_en : b1.rd_en, 32'(re));
        chk($sformatf("d%0d rd_addr @%0d", d, c), d ? b2.rd_addr : b1.rd_addr, 32'(ra));
        chk($sformatf("d%0d wr_en @%0d", d, c), d ? b2.wr_en : b1.wr_en, 32'(we));
        chk($sformatf("d%0d wr_addr @%0d", d, c), d ? b2.wr_addr : b1.wr_addr, 32'(wa));
        chk($sformatf("d%0d rd_start @%0d", d, c), d ? b2.rd_start : b1.rd_start, 32'(rs));
        chk($sformatf("d%0d busy @%0d", d, c), d ? b2.busy : b1.busy, 32'(bz));
        chk($sformatf("d%0d decoder_hold @%0d", d, c), d ? b2.decoder_hold : b1.decoder_hold, 32'(pend[d]));
        chk($sformatf("d%0d overflow @%0d", d, c), d ? b2.overflow : b1.overflow, 32'(ovf[d]));
    endtask

    always @(negedge clk) begin
        fd_h[cyc]  = fd;
        fr_h[cyc]  = fr;
        rst_h[cyc] = rst;
        if (cyc >= 1)
            for (int d = 0; d < 2; d++) begin
                mstep(d, cyc);
                cmp(d, cyc);
            end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int c);
        goto(c);
        fd = 1'b1;
        goto(c + 1);
        fd = 1'b0;
    endtask

    initial begin
        goto(2);
        chk("reset rd_en", b1.rd_en, 0);
        chk("reset busy", b1.busy, 0);
        chk("reset wr_en", b2.wr_en, 0);
        goto(3);
        rst = 1'b1;
        fr  = 1'b1;
        // single frame, frame_done at cycle 10
        pulse(10);
        goto(12);
        chk("A first rd_en", b1.rd_en, 1);
        chk("A first rd_addr", b1.rd_addr, 0);
        goto(15);
        chk("A2 wr_en before lag", b2.wr_en, 0);
        goto(16);
        chk("A wr_addr", b1.wr_addr, 2);
        chk("A2 first wr_en", b2.wr_en, 1);
        chk("A2 first wr_addr", b2.wr_addr, 0);
        goto(28);
        chk("A last rd_addr", b1.rd_addr, 16);
        goto(29);
        chk("A rd_en off", b1.rd_en, 0);
        chk("A rd_addr idle", b1.rd_addr, 0);
        goto(30);
        chk("A last wr_addr", b1.wr_addr, 16);
        chk("A rd_start not yet", b1.rd_start, 0);
        goto(31);
        chk("A rd_start on", b1.rd_start, 1);
        chk("A wr_en off", b1.wr_en, 0);
        goto(33);
        chk("A2 rd_start on", b2.rd_start, 1);
        goto(35);
        chk("A2 rd_start last", b2.rd_start, 1);
        goto(36);
        chk("A2 rd_start off", b2.rd_start, 0);
        chk("A2 busy off", b2.busy, 0);
        goto(50);
        chk("A rd_start last", b1.rd_start, 1);
        goto(51);
        chk("A busy off", b1.busy, 0);
        // fifo not ready when frame_done arrives
        goto(55);
        fr = 1'b0;
        pulse(60);
        goto(65);
        chk("B hold", b1.decoder_hold, 1);
        chk("B idle", b1.busy, 0);
        goto(70);
        fr = 1'b1;
        goto(71);
        chk("B not started", b1.rd_en, 0);
        goto(72);
        chk("B started", b1.rd_en, 1);
        chk("B hold cleared", b1.decoder_hold, 0);
        // pending during ISSUE, then overflow
        pulse(120);
        pulse(130);
        goto(135);
        chk("C hold", b1.decoder_hold, 1);
        chk("C no overflow", b1.overflow, 0);
        pulse(140);
        goto(141);
        chk("C overflow late", b1.overflow, 0);
        goto(142);
        chk("C overflow set", b1.overflow, 1);
        goto(161);
        chk("C gap idle", b1.busy, 0);
        goto(162);
        chk("C second start", b1.rd_en, 1);
        chk("C second addr", b1.rd_addr, 0);
        pulse(170);
        // frame_done lands on the edge that consumes the pending one
        pulse(200);
        goto(202);
        chk("C3 start", b1.rd_en, 1);
        chk("C3 repending", b1.decoder_hold, 1);
        goto(242);
        chk("C4 start", b1.rd_en, 1);
        chk("C4 hold cleared", b1.decoder_hold, 0);
        chk("C4 overflow sticky", b1.overflow, 1);
        // reset mid-ISSUE
        pulse(290);
        goto(300);
        chk("D rd_addr 8", b1.rd_addr, 8);
        rst = 1'b0;
        goto(301);
        rst = 1'b1;
        chk("D rd_en", b1.rd_en, 0);
        chk("D wr_en", b1.wr_en, 0);
        chk("D overflow", b1.overflow, 0);
        chk("D2 wr_en", b2.wr_en, 0);
        goto(303);
        chk("D no residual wr_en", b1.wr_en, 0);
        pulse(320);
        goto(322);
        chk("D restart rd_en", b1.rd_en, 1);
        chk("D restart addr", b1.rd_addr, 0);
        goto(370);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/hd_unload_scheduler.md
HD_UNLOAD_SCHEDULER -- requirements
Module: hd_unload_scheduler

Interface
REQ-001 Parameter ADDRESSWIDTH, default 5: width of rd_addr/wr_addr.
REQ-002 Parameter UNLOADCOUNT, default 17: words unloaded per frame (rows 0..UNLOADCOUNT-1).
REQ-003 Parameter RDLAT, default 2: LLR-memory read latency in clk cycles, range 1..4.
REQ-004 Parameter SYNC_WAITCYCLES, default 20: rd_start pulse stretch in clk cycles, range 1..255, sized for Tout_clk/Tclk.
REQ-005 clk  input  1  decoder-core clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 frame_done  input  1  one-cycle pulse; decoder core has a decoded frame ready.
REQ-008 fifo_ready  input  1  level; output FIFO is drained and may accept a new frame.
REQ-009 rd_en  output  1  read request to LLR/HD memory.
REQ-010 rd_addr  output  ADDRESSWIDTH  read row address.
REQ-011 wr_en  output  1  write enable to output FIFO; equals rd_en delayed RDLAT cycles.
REQ-012 wr_addr  output  ADDRESSWIDTH  FIFO write address; equals rd_addr delayed RDLAT cycles.
REQ-013 rd_start  output  1  stretched start to FIFO read side (out_clk domain).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 decoder_hold  output  1  backpressure; high while a frame is pending.
REQ-016 overflow  output  1  sticky error; a frame_done was lost.

Function
REQ-017 States IDLE, ISSUE, DRAIN, SYNC; encoding free.
REQ-018 pending flag set by frame_done when the frame cannot start in the same cycle; cleared when IDLE->ISSUE consumes it.
REQ-019 IDLE->ISSUE when (frame_done or pending) and fifo_ready; otherwise stay in IDLE.
REQ-020 ISSUE: rd_en=1, rd_addr starts at 0 and increments by 1 each cycle; exactly UNLOADCOUNT cycles; after rd_addr==UNLOADCOUNT-1, go to DRAIN.
REQ-021 rd_addr SHALL be 0 whenever rd_en=0; no wrap past UNLOADCOUNT-1.
REQ-022 DRAIN lasts exactly RDLAT cycles so the final wr_en issues; then go to SYNC.
REQ-023 SYNC: rd_start=1 for exactly SYNC_WAITCYCLES consecutive cycles, counted by an internal counter; then go to IDLE.
REQ-024 First rd_start cycle SHALL follow the last wr_en cycle by at least 1 cycle.
REQ-025 wr_en/wr_addr pipeline is an RDLAT-deep shift register, independent of state; the first write occurs RDLAT cycles after the first read.
REQ-026 frame_done while busy, or in IDLE with fifo_ready=0, sets pending; frame_done while pending=1 sets overflow and the frame is dropped; pending stays 1.
REQ-027 frame_done in the same cycle as IDLE->ISSUE consumption of pending sets pending again rather than setting overflow.
REQ-028 decoder_hold = pending, registered.
REQ-029 fifo_ready is sampled only in IDLE; deassertion mid-frame has no effect.
REQ-030 Back-to-back frames: IDLE lasts a minimum of 1 cycle between SYNC exit and the next ISSUE.

Reset
REQ-031 rst=0 at a clk edge: state=IDLE; pending, overflow, internal counters, and delay pipeline cleared.
REQ-032 Outputs during and after reset: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, rd_start=0, busy=0, decoder_hold=0, overflow=0.
REQ-033 Reset mid-ISSUE/DRAIN/SYNC aborts at once; no residual wr_en is emitted from the cleared pipeline.
REQ-034 overflow clears only on reset.

Verification
REQ-035 Defaults, fifo_ready=1, frame_done pulse at cycle T -> rd_en high T+2..T+18 with rd_addr 0..16; wr_en high T+4..T+20 with wr_addr 0..16; rd_start high T+21..T+40; busy falls at T+41.
REQ-036 fifo_ready=0, frame_done pulse, then fifo_ready=1 10 cycles later -> decoder_hold=1 until consumed; ISSUE starts 2 cycles after fifo_ready rises.
REQ-037 Second frame_done during ISSUE -> pending=1 and decoder_hold=1; the second frame starts 1 IDLE cycle after SYNC ends; overflow stays 0.
REQ-038 Third frame_done while pending=1 -> overflow=1 and remains 1 through later frames until rst=0.
REQ-039 rst=0 for 1 cycle at rd_addr=8 -> all outputs 0 on the next cycle, no further wr_en, and a subsequent frame_done restarts at rd_addr=0.
REQ-040 RDLAT=4, SYNC_WAITCYCLES=3 -> wr_en lags rd_en by 4 cycles; rd_start is exactly 3 cycles wide.
